// File: rtl/parsed_meta_queue_if.sv
// Parser metadata record type and the parser-to-classifier handshake bundle
// that the metadata queue sits on.
package parser_pkg;
   typedef struct packed {
      logic        is_ipv4;
      logic        is_ipv6;
      logic        is_tcp;
      logic        is_udp;
      logic [7:0]  ip_proto;
      logic [15:0] l4_src_port;
      logic [15:0] l4_dst_port;
   } parsed_metadata_t;
endpackage

// Ingress: metadata is captured on every cycle meta_valid is high; there is no
// backpressure. Egress: m_meta transfers on a cycle where m_meta_valid and
// m_meta_ready are both high; once m_meta_valid rises, m_meta and m_meta_valid
// hold until that transfer, and m_meta_ready never reaches them combinationally.
interface parsed_meta_queue_if;
   import parser_pkg::*;

   parsed_metadata_t metadata;
   logic             meta_valid;
   parsed_metadata_t m_meta;
   logic             m_meta_valid;
   logic             m_meta_ready;

   modport slave (
      input  metadata,
      input  meta_valid,
      input  m_meta_ready,
      output m_meta,
      output m_meta_valid
   );

   modport master (
      output metadata,
      output meta_valid,
      output m_meta_ready,
      input  m_meta,
      input  m_meta_valid
   );
endinterface

// File: rtl/parsed_meta_queue.sv
// First-word-fall-through queue for parser metadata, with overflow drop
// counting and per-protocol accepted-record statistics.
module parsed_meta_queue
   import parser_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int AFULL_TH = 6,
   parameter int CNT_W    = 16
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   parsed_meta_queue_if.slave      q,
   output logic [$clog2(DEPTH):0]  occupancy,
   output logic                    almost_full,
   input  logic                    clear_stats,
   output logic [CNT_W-1:0]        drop_count,
   output logic [CNT_W-1:0]        ipv4_count,
   output logic [CNT_W-1:0]        ipv6_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] FULL_OCC  = OCC_W'(DEPTH);
   localparam logic [OCC_W-1:0] AFULL_OCC = OCC_W'(AFULL_TH);
   localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   parsed_metadata_t mem_q [DEPTH];
   parsed_metadata_t mem_d [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             afull_q, afull_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic [CNT_W-1:0] v4_q, v4_d;
   logic [CNT_W-1:0] v6_q, v6_d;

   logic pop;
   logic push;
   logic full;

   always_comb begin
      pop      = (occ_q != '0) && q.m_meta_ready;
      full     = (occ_q == FULL_OCC);
      // When full, a same-cycle pop frees the slot the write pointer aims at.
      push     = q.meta_valid && (!full || pop);

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      drop_d   = drop_q;
      v4_d     = v4_q;
      v6_d     = v6_q;

      if (push) begin
         mem_d[wr_ptr_q] = q.metadata;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end

      case ({push, pop})
         2'b10:   occ_d = occ_q + OCC_ONE;
         2'b01:   occ_d = occ_q - OCC_ONE;
         default: occ_d = occ_q;
      endcase
      afull_d = (occ_d >= AFULL_OCC);

      if (q.meta_valid && !push && (drop_q != CNT_MAX)) drop_d = drop_q + CNT_ONE;
      if (push && q.metadata.is_ipv4 && (v4_q != CNT_MAX)) v4_d = v4_q + CNT_ONE;
      if (push && q.metadata.is_ipv6 && (v6_q != CNT_MAX)) v6_d = v6_q + CNT_ONE;

      // Clear overrides any increment landing in the same cycle.
      if (clear_stats) begin
         drop_d = '0;
         v4_d   = '0;
         v6_d   = '0;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         afull_q  <= 1'b0;
         drop_q   <= '0;
         v4_q     <= '0;
         v6_q     <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         afull_q  <= afull_d;
         drop_q   <= drop_d;
         v4_q     <= v4_d;
         v6_q     <= v6_d;
      end
   end

   // Storage carries no reset; entries are only observable behind m_meta_valid.
   always_ff @(posedge aclk) begin
      mem_q <= mem_d;
   end

   assign q.m_meta       = mem_q[rd_ptr_q];
   assign q.m_meta_valid = (occ_q != '0);
   assign occupancy      = occ_q;
   assign almost_full    = afull_q;
   assign drop_count     = drop_q;
   assign ipv4_count     = v4_q;
   assign ipv6_count     = v6_q;

endmodule

// File: doc/parsed_meta_queue.md
# parsed_meta_queue

Buffers `parsed_metadata_t` records from the packet parser's `metadata`/`meta_valid` output. That output is a single-cycle pulse with no backpressure. This block sits directly downstream of the parser and presents the records on a valid/ready interface to the classification stage. It uses a first-word-fall-through circular buffer, counts records dropped on overflow, and keeps per-protocol statistics.

## Interface
- `DEPTH`, 8: number of buffered records; power of two, 2..256.
- `AFULL_TH`, 6: `almost_full` asserts when occupancy ≥ `AFULL_TH`; legal range 1..`DEPTH`.
- `CNT_W`, 16: width of the statistics counters.
- `aclk`  in  1  Single clock; all logic is on the rising edge.
- `aresetn`  in  1  Asynchronous reset, active-low.
- `metadata`  in  `$bits(parsed_metadata_t)`  Record from the parser (`parser_pkg::parsed_metadata_t`).
- `meta_valid`  in  1  Push strobe; one record per high cycle; no backpressure.
- `m_meta`  out  `$bits(parsed_metadata_t)`  Head-of-queue record.
- `m_meta_valid`  out  1  Queue is non-empty; `m_meta` is valid.
- `m_meta_ready`  in  1  Consumer accepts the head record.
- `occupancy`  out  `$clog2(DEPTH)+1`  Number of stored records.
- `almost_full`  out  1  `occupancy` ≥ `AFULL_TH`.
- `clear_stats`  in  1  Synchronous pulse that zeroes all three counters.
- `drop_count`  out  `CNT_W`  Records lost to overflow; saturating.
- `ipv4_count`  out  `CNT_W`  Accepted records with `is_ipv4`=1; saturating.
- `ipv6_count`  out  `CNT_W`  Accepted records with `is_ipv6`=1; saturating.

## Operation
- Storage: `DEPTH`-entry register array.
  - Write pointer and read pointer are each `$clog2(DEPTH)` bits and wrap naturally.
  - A separate occupancy counter distinguishes full from empty.
- Pop: occurs when `m_meta_valid` && `m_meta_ready`. The read pointer increments.
- Push: occurs when `meta_valid` && (occupancy < `DEPTH` || pop this cycle).
  - `metadata` is written at the write pointer, and the write pointer increments.
- Full with a simultaneous pop: the push is accepted and occupancy stays `DEPTH`.
- Full with no pop: the record is discarded and `drop_count` increments. Memory and pointers are unchanged.
- Empty: `m_meta_valid`=0 and `m_meta_ready` is ignored. An empty-queue push is not bypassed combinationally to the output.
- Occupancy update: +1 on push only, −1 on pop only, unchanged on both or neither.
- `m_meta` = memory at the read pointer, which is first-word-fall-through. The value is undefined-but-stable while `m_meta_valid`=0.
- `m_meta_valid` = (occupancy ≠ 0).
- Statistics:
  - `ipv4_count` and `ipv6_count` increment only on accepted pushes, keyed on the record's flags.
  - A record with both flags 0 is stored but not counted.
- Counters saturate at 2^`CNT_W`−1.
- If `clear_stats` coincides with an increment, clear wins and the counter becomes 0.
- `clear_stats` does not affect the queue contents, pointers or occupancy.
- AXIS-style stability: once `m_meta_valid`=1, `m_meta` and `m_meta_valid` hold until popped. A push never disturbs the head entry.

## Timing
- Reset (`aresetn`=0, asynchronous): both pointers=0, `occupancy`=0, `m_meta_valid`=0, `almost_full`=0, all counters=0.
  - Memory contents are not reset.
  - `m_meta` has no defined reset value. The bench must ignore it while `m_meta_valid`=0.
- Reset mid-operation: all buffered records are lost. No pop or push is registered in the reset cycle.
- Latency: a push sampled at edge N gives `m_meta_valid`=1 with that record after edge N (one cycle), if the queue was empty.
- Throughput: one push and one pop per cycle sustained. A continuously full queue with `m_meta_ready`=1 loses no records.
- `occupancy`, `almost_full` and the counters are registered and reflect the edge at which the event was sampled. There is no combinational path from `meta_valid` to any output.
- `m_meta_ready` affects only the next-state logic and never drives outputs combinationally.

## Test plan
- Reset, then 3 pushes of IPv4 records A,B,C with `m_meta_ready`=0.
  - Required: `occupancy`=3 and `m_meta`=A.
  - Then raise ready: A,B,C are popped on consecutive cycles, `ipv4_count`=3, `m_meta_valid`=0 afterwards.
- `DEPTH`=8 with `m_meta_ready`=0, 10 pushes.
  - Required: `occupancy`=8, `almost_full`=1 from the 6th push onward, `drop_count`=2.
  - Drain order is records 1..8.
- Queue full with a push and a pop in the same cycle.
  - Required: `occupancy` stays 8, `drop_count` unchanged, the new record appears last in drain order.
- 20 alternating push/pop cycles wrapping the pointers twice, mixing IPv4/IPv6 records.
  - Required: output order matches input order exactly, with the correct split between `ipv4_count` and `ipv6_count`.
- `CNT_W`=4 with 20 IPv6 pushes and continuous ready: `ipv6_count` saturates at 15.
  - Then `clear_stats` together with a push: `ipv6_count`=0 the next cycle.
- Assert `aresetn` low while `occupancy`=5.
  - Required: all outputs return to their reset values immediately (asynchronously).
  - After release, the first push produces `m_meta_valid`=1 one cycle later with the new record.
